fc_relu_seq_ctrl: RTL and testbench
===================================

Name: fc_relu_seq_ctrl

Overview:
Sequencer for one fully-connected neuron datapath: synchronous activation/weight/bias memories, a MAC accumulator, and the registered ReLU stage. For each output neuron it clears the accumulator, streams N_IN activation/weight pairs, adds the bias, waits for the ReLU register, then presents the result index downstream with a valid/ready handshake. One `start` processes all N_OUT neurons of a layer.

Parameters:
N_IN, 16, inputs per neuron (>=1)
N_OUT, 10, neurons per layer (>=1)
IN_AW, $clog2(N_IN) min 1, activation address width
W_AW, $clog2(N_IN*N_OUT) min 1, weight address width
OUT_AW, $clog2(N_OUT) min 1, neuron index width

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
start  in  1  start a layer; sampled only in IDLE
in_addr  out  IN_AW  activation memory read address
w_addr  out  W_AW  weight memory read address, = j*N_IN+i
b_addr  out  OUT_AW  bias memory read address, = current neuron j
acc_clr  out  1  clear accumulator
acc_en  out  1  accumulate mem data (data valid this cycle)
bias_en  out  1  add bias data to accumulator
out_valid  out  1  ReLU output valid for neuron out_idx
out_ready  in  1  downstream accepts
out_idx  out  OUT_AW  neuron index of presented result
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after last neuron accepted

Behaviour:
- One clock `clk`; reset `rst_n` is asynchronous, active-low. On reset: state IDLE, i=0, j=0, all outputs 0.
- Memories have 1-cycle read latency; ReLU has 1-cycle registered latency.
- States: IDLE, CLR, FETCH, DRAIN, BIAS, ACT, OUT, DONE.
- IDLE: start=1 -> CLR, j=0. start in any other state ignored.
- CLR (1 cycle): acc_clr=1, i=0 -> FETCH.
- FETCH (N_IN cycles): in_addr=i, w_addr=j*N_IN+i, i increments; on i==N_IN-1 -> DRAIN. w_addr kept as a running base (base += N_IN per neuron), no multiplier.
- acc_en = registered "FETCH active" flag: high exactly N_IN cycles, delayed one cycle from the addresses (last acc_en falls in DRAIN).
- DRAIN (1 cycle) -> BIAS. BIAS (1 cycle): bias_en=1 (b_addr=j stable since CLR) -> ACT.
- ACT (1 cycle): ReLU register captures -> OUT.
- OUT: out_valid=1, out_idx=j held stable until out_ready=1. On handshake: j==N_OUT-1 -> DONE, else j++ -> CLR. out_ready outside OUT is ignored.
- DONE (1 cycle): done=1, busy=1 -> IDLE.
- Latency start->first out_valid: N_IN+5 cycles. Per-neuron period with out_ready tied high: N_IN+5 cycles.
- acc_clr, acc_en, and bias_en are mutually exclusive in every cycle.
- Addresses are held at their last value outside FETCH.
- N_IN=1: FETCH lasts exactly one cycle. N_OUT=1: the first handshake goes to DONE.
- Reset mid-layer: immediate abort to IDLE with all outputs 0. No partial results are retained.

Decomposition:
- Package nn_ctrl_pkg: state enum (8 states, 3-bit), clog2-with-min-1 function, defaults for N_IN/N_OUT.
- One sub-module: fc_addr_gen, holding the i/j counters, running weight base, and wrap/last flags. The FSM and the acc_en delay register stay in the top module.

Test Plan:
- Reset: hold rst_n=0 with start=1 -> all outputs 0, busy=0; release -> stays IDLE until start.
- Nominal N_IN=4, N_OUT=3, out_ready=1, acts=1..4, weights=1, bias=-20/0/5 -> acc_en has 4 pulses per neuron. w_addr sequence 0..3, 4..7, 8..11. ReLU outputs 0/10/15 at out_idx 0/1/2. done pulses once, 9 cycles per neuron.
- Backpressure: out_ready=0 for 5 cycles at neuron 1 -> out_valid and out_idx=1 stay stable, no acc_en/acc_clr during the stall; progress resumes the cycle after out_ready=1.
- start pulsed during FETCH and OUT -> ignored; layer completes with exactly N_OUT handshakes and one done.
- Edge N_IN=1, N_OUT=1 -> CLR, FETCH, DRAIN, BIAS, ACT, OUT, DONE, IDLE with single acc_en; latency 6 cycles to out_valid.
- Async reset asserted mid-FETCH of neuron 2 -> outputs 0 immediately (no clock edge); new start restarts at j=0, w_addr=0.

Source files
------------

// File: rtl/nn_ctrl_pkg.sv
// Shared definitions for the fully-connected neuron sequencer: FSM state
// encoding, default layer geometry and an address-width helper.
package nn_ctrl_pkg;

   localparam int N_IN_DEF  = 16;
   localparam int N_OUT_DEF = 10;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLR   = 3'd1,
      ST_FETCH = 3'd2,
      ST_DRAIN = 3'd3,
      ST_BIAS  = 3'd4,
      ST_ACT   = 3'd5,
      ST_OUT   = 3'd6,
      ST_DONE  = 3'd7
   } fc_state_e;

   // Address width for a memory of 'value' entries, never narrower than 1 bit.
   function automatic int clog2_min1(input int value);
      int result;
      if (value <= 1) begin
         result = 1;
      end else begin
         result = $clog2(value);
      end
      return result;
   endfunction

endpackage

// File: rtl/fc_addr_gen.sv
// Address generator for the neuron sequencer. Keeps the input index i, the
// neuron index j and a running weight base so the weight address j*N_IN+i is
// produced by increments only. All addresses hold outside the fetch phase.
module fc_addr_gen
   import nn_ctrl_pkg::*;
#(
   parameter int N_IN   = N_IN_DEF,
   parameter int N_OUT  = N_OUT_DEF,
   parameter int IN_AW  = clog2_min1(N_IN),
   parameter int W_AW   = clog2_min1(N_IN * N_OUT),
   parameter int OUT_AW = clog2_min1(N_OUT)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              layer_start,
   input  logic              neuron_clr,
   input  logic              fetch_step,
   input  logic              next_neuron,
   output logic [IN_AW-1:0]  in_addr,
   output logic [W_AW-1:0]   w_addr,
   output logic [OUT_AW-1:0] b_addr,
   output logic              i_last,
   output logic              j_last
);

   localparam logic [IN_AW-1:0]  I_LAST   = IN_AW'(N_IN - 1);
   localparam logic [OUT_AW-1:0] J_LAST   = OUT_AW'(N_OUT - 1);
   localparam logic [W_AW-1:0]   W_STRIDE = W_AW'(N_IN);

   logic [IN_AW-1:0]  i_r;
   logic [OUT_AW-1:0] j_r;
   logic [W_AW-1:0]   base_r;
   logic [W_AW-1:0]   w_addr_r;

   // Input index and weight address: rewind to the neuron base, then step once per fetch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_r      <= {IN_AW{1'b0}};
         w_addr_r <= {W_AW{1'b0}};
      end else if (neuron_clr) begin
         i_r      <= {IN_AW{1'b0}};
         w_addr_r <= base_r;
      end else if (fetch_step) begin
         i_r      <= i_r + IN_AW'(1'b1);
         w_addr_r <= w_addr_r + W_AW'(1'b1);
      end else begin
         i_r      <= i_r;
         w_addr_r <= w_addr_r;
      end
   end

   // Neuron index and running weight base: restart per layer, advance per accepted result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         j_r    <= {OUT_AW{1'b0}};
         base_r <= {W_AW{1'b0}};
      end else if (layer_start) begin
         j_r    <= {OUT_AW{1'b0}};
         base_r <= {W_AW{1'b0}};
      end else if (next_neuron) begin
         j_r    <= j_r + OUT_AW'(1'b1);
         base_r <= base_r + W_STRIDE;
      end else begin
         j_r    <= j_r;
         base_r <= base_r;
      end
   end

   assign in_addr = i_r;
   assign w_addr  = w_addr_r;
   assign b_addr  = j_r;
   assign i_last  = (i_r == I_LAST);
   assign j_last  = (j_r == J_LAST);

endmodule

// File: rtl/fc_relu_seq_ctrl.sv
// Sequencer for one fully-connected neuron with ReLU. Per neuron: clear the
// accumulator, stream N_IN activation/weight pairs, add the bias, wait one
// cycle for the ReLU register, then hand the result index downstream.
// Every control output is a register so downstream sees glitch-free strobes.
module fc_relu_seq_ctrl
   import nn_ctrl_pkg::*;
#(
   parameter int N_IN   = N_IN_DEF,
   parameter int N_OUT  = N_OUT_DEF,
   parameter int IN_AW  = clog2_min1(N_IN),
   parameter int W_AW   = clog2_min1(N_IN * N_OUT),
   parameter int OUT_AW = clog2_min1(N_OUT)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [IN_AW-1:0]  in_addr,
   output logic [W_AW-1:0]   w_addr,
   output logic [OUT_AW-1:0] b_addr,
   output logic              acc_clr,
   output logic              acc_en,
   output logic              bias_en,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_AW-1:0] out_idx,
   output logic              busy,
   output logic              done
);

   localparam logic [2:0] S_IDLE  = 3'(ST_IDLE);
   localparam logic [2:0] S_CLR   = 3'(ST_CLR);
   localparam logic [2:0] S_FETCH = 3'(ST_FETCH);
   localparam logic [2:0] S_DRAIN = 3'(ST_DRAIN);
   localparam logic [2:0] S_BIAS  = 3'(ST_BIAS);
   localparam logic [2:0] S_ACT   = 3'(ST_ACT);
   localparam logic [2:0] S_OUT   = 3'(ST_OUT);
   localparam logic [2:0] S_DONE  = 3'(ST_DONE);

   logic [2:0]        state_r;
   logic [2:0]        state_nxt_s;
   logic              layer_start_s;
   logic              neuron_clr_s;
   logic              fetch_step_s;
   logic              next_neuron_s;
   logic              i_last_s;
   logic              j_last_s;
   logic [OUT_AW-1:0] b_addr_s;
   logic              acc_clr_r;
   logic              acc_en_r;
   logic              bias_en_r;
   logic              out_valid_r;
   logic              busy_r;
   logic              done_r;

   fc_addr_gen #(
      .N_IN   (N_IN),
      .N_OUT  (N_OUT),
      .IN_AW  (IN_AW),
      .W_AW   (W_AW),
      .OUT_AW (OUT_AW)
   ) u_addr_gen (
      .clk         (clk),
      .rst_n       (rst_n),
      .layer_start (layer_start_s),
      .neuron_clr  (neuron_clr_s),
      .fetch_step  (fetch_step_s),
      .next_neuron (next_neuron_s),
      .in_addr     (in_addr),
      .w_addr      (w_addr),
      .b_addr      (b_addr_s),
      .i_last      (i_last_s),
      .j_last      (j_last_s)
   );

   // Next-state logic; start and out_ready only matter in IDLE and OUT respectively.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (start) begin
               state_nxt_s = S_CLR;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_CLR:   state_nxt_s = S_FETCH;
         S_FETCH: begin
            if (i_last_s) begin
               state_nxt_s = S_DRAIN;
            end else begin
               state_nxt_s = S_FETCH;
            end
         end
         S_DRAIN: state_nxt_s = S_BIAS;
         S_BIAS:  state_nxt_s = S_ACT;
         S_ACT:   state_nxt_s = S_OUT;
         S_OUT: begin
            if (out_ready && j_last_s) begin
               state_nxt_s = S_DONE;
            end else if (out_ready) begin
               state_nxt_s = S_CLR;
            end else begin
               state_nxt_s = S_OUT;
            end
         end
         S_DONE:  state_nxt_s = S_IDLE;
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // Counter strobes for the address generator, decoded from the current state.
   always_comb begin
      layer_start_s = (state_r == S_IDLE) && start;
      neuron_clr_s  = (state_r == S_CLR);
      fetch_step_s  = (state_r == S_FETCH) && !i_last_s;
      next_neuron_s = (state_r == S_OUT) && out_ready && !j_last_s;
   end

   // State register and per-state control outputs registered from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= S_IDLE;
         acc_clr_r   <= 1'b0;
         bias_en_r   <= 1'b0;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         acc_clr_r   <= (state_nxt_s == S_CLR);
         bias_en_r   <= (state_nxt_s == S_BIAS);
         out_valid_r <= (state_nxt_s == S_OUT);
         busy_r      <= (state_nxt_s != S_IDLE);
         done_r      <= (state_nxt_s == S_DONE);
      end
   end

   // Accumulate enable trails the fetch addresses by the one-cycle memory latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_en_r <= 1'b0;
      end else begin
         acc_en_r <= (state_r == S_FETCH);
      end
   end

   assign b_addr    = b_addr_s;
   assign out_idx   = b_addr_s;
   assign acc_clr   = acc_clr_r;
   assign acc_en    = acc_en_r;
   assign bias_en   = bias_en_r;
   assign out_valid = out_valid_r;
   assign busy      = busy_r;
   assign done      = done_r;

endmodule

// File: tb/tb_fc_relu_seq_ctrl.sv
// Directed bench for fc_relu_seq_ctrl: one instance with N_IN=4/N_OUT=3 and
// one with N_IN=1/N_OUT=1, each feeding a small memory + MAC + ReLU model.
module tb_fc_relu_seq_ctrl;

   logic       clk;
   logic       rst_n;

   logic       start_a, ready_a;
   logic [1:0] in_addr_a, b_addr_a, out_idx_a;
   logic [3:0] w_addr_a;
   logic       acc_clr_a, acc_en_a, bias_en_a, out_valid_a, busy_a, done_a;

   logic       start_b, ready_b;
   logic [0:0] in_addr_b, w_addr_b, b_addr_b, out_idx_b;
   logic       acc_clr_b, acc_en_b, bias_en_b, out_valid_b, busy_b, done_b;

   int n_checks;
   int n_fail;

   fc_relu_seq_ctrl #(.N_IN(4), .N_OUT(3)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a),
      .in_addr(in_addr_a), .w_addr(w_addr_a), .b_addr(b_addr_a),
      .acc_clr(acc_clr_a), .acc_en(acc_en_a), .bias_en(bias_en_a),
      .out_valid(out_valid_a), .out_ready(ready_a), .out_idx(out_idx_a),
      .busy(busy_a), .done(done_a)
   );

   fc_relu_seq_ctrl #(.N_IN(1), .N_OUT(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b),
      .in_addr(in_addr_b), .w_addr(w_addr_b), .b_addr(b_addr_b),
      .acc_clr(acc_clr_b), .acc_en(acc_en_b), .bias_en(bias_en_b),
      .out_valid(out_valid_b), .out_ready(ready_b), .out_idx(out_idx_b),
      .busy(busy_b), .done(done_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Datapath models: synchronous memories, accumulator, registered ReLU.
   int act_mem_a [4];
   int w_mem_a [16];
   int b_mem_a [4];
   int act_q_a, w_q_a, b_q_a, acc_a, relu_a;
   int act_mem_b [2];
   int w_mem_b [2];
   int b_mem_b [2];
   int act_q_b, w_q_b, b_q_b, acc_b, relu_b;

   always @(posedge clk) begin
      act_q_a <= act_mem_a[in_addr_a];
      w_q_a   <= w_mem_a[w_addr_a];
      b_q_a   <= b_mem_a[b_addr_a];
      if (acc_clr_a) acc_a <= 0;
      else if (acc_en_a) acc_a <= acc_a + act_q_a * w_q_a;
      else if (bias_en_a) acc_a <= acc_a + b_q_a;
      relu_a <= (acc_a < 0) ? 0 : acc_a;
      act_q_b <= act_mem_b[in_addr_b];
      w_q_b   <= w_mem_b[w_addr_b];
      b_q_b   <= b_mem_b[b_addr_b];
      if (acc_clr_b) acc_b <= 0;
      else if (acc_en_b) acc_b <= acc_b + act_q_b * w_q_b;
      else if (bias_en_b) acc_b <= acc_b + b_q_b;
      relu_b <= (acc_b < 0) ? 0 : acc_b;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      logic [15:0] outs;
      rst_n = 1'b0; start_a = 1'b1; start_b = 1'b1; ready_a = 1'b1; ready_b = 1'b1;
      tick; tick;
      outs = {in_addr_a, w_addr_a, b_addr_a, acc_clr_a, acc_en_a, bias_en_a,
              out_valid_a, out_idx_a, busy_a, done_a};
      n_checks++;
      if (outs !== 16'h0000) begin
         n_fail++; $display("FAIL reset_outs_a: got %h expected 0000", outs);
      end
      outs = {6'd0, in_addr_b, w_addr_b, b_addr_b, acc_clr_b, acc_en_b, bias_en_b,
              out_valid_b, out_idx_b, busy_b, done_b};
      n_checks++;
      if (outs !== 16'h0000) begin
         n_fail++; $display("FAIL reset_outs_b: got %h expected 0000", outs);
      end
      rst_n = 1'b1; start_a = 1'b0; start_b = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick;
         n_checks++;
         if ({busy_a, busy_b, acc_clr_a, acc_clr_b} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_idle c=%0d: got %b expected 0000", c,
                               {busy_a, busy_b, acc_clr_a, acc_clr_b});
         end
      end
   endtask

   task automatic test_nominal;
      int j, p, acc_pulses;
      logic [5:0] exp_ctl, got_ctl;
      int exp_relu [3];
      exp_relu = '{0, 10, 15};
      acc_pulses = 0;
      ready_a = 1'b1;
      start_a = 1'b1; tick; start_a = 1'b0;
      for (int c = 0; c < 27; c++) begin
         j = c / 9; p = c % 9;
         exp_ctl = {(p == 0), (p >= 2 && p <= 5), (p == 6), (p == 8), 1'b1, 1'b0};
         got_ctl = {acc_clr_a, acc_en_a, bias_en_a, out_valid_a, busy_a, done_a};
         if (acc_en_a) acc_pulses++;
         n_checks++;
         if (got_ctl !== exp_ctl) begin
            n_fail++; $display("FAIL nominal_ctl c=%0d: got %b expected %b", c, got_ctl, exp_ctl);
         end
         if (p >= 1 && p <= 4) begin
            n_checks++;
            if (in_addr_a !== 2'(p - 1) || w_addr_a !== 4'(j * 4 + p - 1)) begin
               n_fail++; $display("FAIL nominal_addr c=%0d: got in=%0d w=%0d expected in=%0d w=%0d",
                                  c, in_addr_a, w_addr_a, p - 1, j * 4 + p - 1);
            end
         end
         if (p == 6) begin
            n_checks++;
            if (b_addr_a !== 2'(j)) begin
               n_fail++; $display("FAIL nominal_baddr c=%0d: got %0d expected %0d", c, b_addr_a, j);
            end
         end
         if (p == 8) begin
            n_checks++;
            if (out_idx_a !== 2'(j) || relu_a !== exp_relu[j]) begin
               n_fail++; $display("FAIL nominal_result c=%0d: got idx=%0d relu=%0d expected idx=%0d relu=%0d",
                                  c, out_idx_a, relu_a, j, exp_relu[j]);
            end
         end
         tick;
      end
      got_ctl = {acc_clr_a, acc_en_a, bias_en_a, out_valid_a, busy_a, done_a};
      n_checks++;
      if (got_ctl !== 6'b000011) begin
         n_fail++; $display("FAIL nominal_done: got %b expected 000011", got_ctl);
      end
      n_checks++;
      if (acc_pulses != 12) begin
         n_fail++; $display("FAIL nominal_acc_pulses: got %0d expected 12", acc_pulses);
      end
      tick;
      got_ctl = {acc_clr_a, acc_en_a, bias_en_a, out_valid_a, busy_a, done_a};
      n_checks++;
      if (got_ctl !== 6'b000000) begin
         n_fail++; $display("FAIL nominal_idle: got %b expected 000000", got_ctl);
      end
   endtask

   task automatic test_backpressure;
      int done_k;
      done_k = -1;
      ready_a = 1'b1;
      start_a = 1'b1; tick; start_a = 1'b0;
      for (int k = 0; k < 80; k++) begin
         if (k >= 17 && k <= 22) begin
            n_checks++;
            if ({out_valid_a, out_idx_a, acc_en_a, acc_clr_a} !== 5'b1_01_00 || relu_a !== 10) begin
               n_fail++; $display("FAIL stall_hold k=%0d: got v=%b idx=%0d en=%b clr=%b relu=%0d expected v=1 idx=1 en=0 clr=0 relu=10",
                                  k, out_valid_a, out_idx_a, acc_en_a, acc_clr_a, relu_a);
            end
         end
         if (k == 23) begin
            n_checks++;
            if ({acc_clr_a, out_valid_a, b_addr_a} !== 4'b1_0_10) begin
               n_fail++; $display("FAIL stall_resume: got clr=%b v=%b b=%0d expected clr=1 v=0 b=2",
                                  acc_clr_a, out_valid_a, b_addr_a);
            end
         end
         if (done_a) begin
            done_k = k;
            break;
         end
         ready_a = (k < 9 || k >= 22) ? 1'b1 : 1'b0;
         tick;
      end
      ready_a = 1'b1;
      n_checks++;
      if (done_k != 32) begin
         n_fail++; $display("FAIL stall_done_cycle: got %0d expected 32", done_k);
      end
      tick;
   endtask

   task automatic test_start_ignored;
      int hs, dones, done_k;
      int idx_seen [3];
      hs = 0; dones = 0; done_k = -1;
      ready_a = 1'b1;
      start_a = 1'b1; tick; start_a = 1'b0;
      for (int k = 0; k < 80; k++) begin
         if (out_valid_a && ready_a) begin
            if (hs < 3) idx_seen[hs] = int'(out_idx_a);
            hs++;
         end
         if (done_a) begin
            dones++; done_k = k;
            break;
         end
         start_a = (k == 2 || k == 8 || k == 17) ? 1'b1 : 1'b0;
         tick;
      end
      start_a = 1'b0;
      n_checks++;
      if (hs != 3 || done_k != 27) begin
         n_fail++; $display("FAIL start_ignored_count: got hs=%0d done_k=%0d expected hs=3 done_k=27", hs, done_k);
      end
      for (int n = 0; n < 3; n++) begin
         n_checks++;
         if (hs >= 3 && idx_seen[n] != n) begin
            n_fail++; $display("FAIL start_ignored_idx %0d: got %0d expected %0d", n, idx_seen[n], n);
         end
      end
      for (int c = 0; c < 3; c++) begin
         tick;
         if (done_a) dones++;
         n_checks++;
         if (busy_a !== 1'b0) begin
            n_fail++; $display("FAIL start_ignored_idle c=%0d: got busy=%b expected 0", c, busy_a);
         end
      end
      n_checks++;
      if (dones != 1) begin
         n_fail++; $display("FAIL start_ignored_dones: got %0d expected 1", dones);
      end
   endtask

   task automatic test_edge;
      logic [5:0] exp_b [8];
      logic [5:0] got;
      int pulses;
      exp_b = '{6'b100010, 6'b000010, 6'b010010, 6'b001010,
                6'b000010, 6'b000110, 6'b000011, 6'b000000};
      pulses = 0;
      ready_b = 1'b1;
      start_b = 1'b1; tick; start_b = 1'b0;
      for (int c = 0; c < 8; c++) begin
         got = {acc_clr_b, acc_en_b, bias_en_b, out_valid_b, busy_b, done_b};
         if (acc_en_b) pulses++;
         n_checks++;
         if (got !== exp_b[c]) begin
            n_fail++; $display("FAIL edge_ctl c=%0d: got %b expected %b", c, got, exp_b[c]);
         end
         if (c == 1) begin
            n_checks++;
            if ({in_addr_b, w_addr_b} !== 2'b00) begin
               n_fail++; $display("FAIL edge_addr: got in=%0d w=%0d expected 0 0", in_addr_b, w_addr_b);
            end
         end
         if (c == 5) begin
            n_checks++;
            if (out_idx_b !== 1'b0 || relu_b !== 5) begin
               n_fail++; $display("FAIL edge_result: got idx=%0d relu=%0d expected idx=0 relu=5", out_idx_b, relu_b);
            end
         end
         tick;
      end
      n_checks++;
      if (pulses != 1) begin
         n_fail++; $display("FAIL edge_acc_pulses: got %0d expected 1", pulses);
      end
   endtask

   task automatic test_async_reset;
      logic [15:0] outs;
      int hs, done_k;
      hs = 0; done_k = -1;
      ready_a = 1'b1;
      start_a = 1'b1; tick; start_a = 1'b0;
      repeat (20) tick;
      n_checks++;
      if ({busy_a, acc_en_a, w_addr_a, b_addr_a} !== 8'b1_1_1001_10) begin
         n_fail++; $display("FAIL areset_pre: got busy=%b en=%b w=%0d b=%0d expected busy=1 en=1 w=9 b=2",
                            busy_a, acc_en_a, w_addr_a, b_addr_a);
      end
      #2 rst_n = 1'b0;
      #1;
      outs = {in_addr_a, w_addr_a, b_addr_a, acc_clr_a, acc_en_a, bias_en_a,
              out_valid_a, out_idx_a, busy_a, done_a};
      n_checks++;
      if (outs !== 16'h0000) begin
         n_fail++; $display("FAIL areset_outs: got %h expected 0000", outs);
      end
      tick;
      rst_n = 1'b1;
      start_a = 1'b1; tick; start_a = 1'b0;
      n_checks++;
      if ({acc_clr_a, b_addr_a} !== 3'b1_00) begin
         n_fail++; $display("FAIL areset_restart_clr: got clr=%b b=%0d expected clr=1 b=0", acc_clr_a, b_addr_a);
      end
      tick;
      n_checks++;
      if ({in_addr_a, w_addr_a} !== 6'b00_0000) begin
         n_fail++; $display("FAIL areset_restart_addr: got in=%0d w=%0d expected 0 0", in_addr_a, w_addr_a);
      end
      for (int k = 1; k < 80; k++) begin
         if (out_valid_a) begin
            if (hs == 0) begin
               n_checks++;
               if (relu_a !== 0) begin
                  n_fail++; $display("FAIL areset_first_relu: got %0d expected 0", relu_a);
               end
            end
            hs++;
         end
         if (done_a) begin
            done_k = k;
            break;
         end
         tick;
      end
      n_checks++;
      if (hs != 3 || done_k != 27) begin
         n_fail++; $display("FAIL areset_layer: got hs=%0d done_k=%0d expected hs=3 done_k=27", hs, done_k);
      end
      tick;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      for (int i = 0; i < 4; i++) act_mem_a[i] = i + 1;
      for (int i = 0; i < 16; i++) w_mem_a[i] = 1;
      b_mem_a = '{-20, 0, 5, 0};
      act_mem_b = '{3, 0};
      w_mem_b   = '{2, 0};
      b_mem_b   = '{-1, 0};
      test_reset();
      test_nominal();
      test_backpressure();
      test_start_ignored();
      test_edge();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
